instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
- Parametrised successor to the fixed-content instruction memory.
- Synchronous-read instruction store with a fetch handshake.
- Clears itself after reset with a hardware sweep instead of an unsynthesisable bulk clear.
- Accepts a runtime program load over a byte-serial port, so test programs are no longer hard-coded.
- Sits between the PC/fetch stage and the boot/test loader.

Parameters:
- INSTR_WIDTH, 19: instruction word width in bits; must be 1..32.
- ADDR_WIDTH, 12: address width.
- DEPTH = 2**ADDR_WIDTH: derived, number of words.
- LOAD_BYTES = ceil(INSTR_WIDTH/8): derived, bytes per word; 3 at default.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request, sampled each cycle.
- fetch_addr  in  ADDR_WIDTH  word address to fetch.
- fetch_valid  out  1  instruction valid; pulses 1 cycle after an accepted request.
- instruction  out  INSTR_WIDTH  registered fetch data.
- mem_ready  out  1  high in RUN state only.
- load_start  in  1  pulse; enter LOAD at load_addr.
- load_addr  in  ADDR_WIDTH  first word address of a load.
- load_byte_valid  in  1  load_byte present.
- load_byte  in  8  program byte, MSB-first within a word.
- load_byte_ready  out  1  high in LOAD state.
- load_stop  in  1  pulse; leave LOAD.
- load_count  out  ADDR_WIDTH+1  words written since the last load_start.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- States:
  - CLEAR: sweep counter writes 0 to one word per cycle, address 0..DEPTH-1.
  - RUN: serves fetches.
  - LOAD: assembles bytes into words.
- Reset, at the first clk edge with rst=1:
  - state=CLEAR, sweep counter=0.
  - fetch_valid=0, instruction=0, mem_ready=0, load_byte_ready=0, load_count=0.
  - byte index=0, partial word register=0.
  - Reset mid-LOAD or mid-CLEAR aborts the operation, discards partial data and restarts the sweep.
- CLEAR: lasts exactly DEPTH cycles after rst deasserts. On the edge writing DEPTH-1, next state=RUN, and mem_ready rises the following cycle. fetch_req, load_start and load_stop are ignored.
- Fetch (RUN only): if fetch_req=1 at an edge, the next cycle gives instruction=mem[fetch_addr] and fetch_valid=1. Latency is 1 and back-to-back requests give one result per cycle. With no request, fetch_valid=0 and instruction holds its last value.
- Enter LOAD: load_start in RUN moves to LOAD.
  - Word pointer=load_addr, byte index=0, load_count=0.
  - A fetch_req in the same cycle is still served, with pre-load contents.
  - In LOAD, fetch_req is ignored and fetch_valid=0.
- LOAD byte accept: a byte is accepted when load_byte_valid=1 and state=LOAD; one byte per cycle.
  - Bytes shift into the partial register.
  - When byte index reaches LOAD_BYTES-1, write mem[ptr] = low INSTR_WIDTH bits of the concatenated bytes. High surplus bits of the first byte are discarded.
  - After the write: ptr+1 modulo DEPTH (wraps DEPTH-1 -> 0), load_count+1 saturating at DEPTH, byte index=0.
- load_stop:
  - Returns to RUN on the next cycle.
  - An incomplete partial word is discarded, with no write.
  - If a byte arrives in the same cycle as load_stop, that byte is accepted first. If it completes a word, the word is written.
- load_start while already in LOAD restarts the load: ptr=load_addr, index=0, count=0, partial word discarded.
- Memory: single write port, used by the sweep or the loader, and one synchronous read port. Read-during-write never occurs because the states are exclusive.

Decomposition:
- Shared package:
  - State enum (CLEAR, RUN, LOAD).
  - Default INSTR_WIDTH/ADDR_WIDTH constants, shared with the PC and decoder.
  - LOAD_BYTES function.
- One natural sub-module: instr_word_assembler. It holds the byte index, partial register, and the word_done/word output, and is reset by rst or load_start.
- The memory array and FSM stay in the top.

Test Plan:
- Reset/clear (ADDR_WIDTH=4, after previously loading nonzero data): rst 1 cycle -> mem_ready low for 16 cycles then high; fetch 0..15 each returns 0, with fetch_valid exactly 1 cycle after each req.
- Basic load: load_start addr=2; bytes 0x01,0xA2,0xF7; load_stop -> load_count=1; fetch 2 returns 19'h1A2F7; fetch 1 and 3 return 0.
- Wrap-around (ADDR_WIDTH=4): load_start addr=15; 6 bytes forming words 0x00001 and 0x7FFFF -> mem[15]=1, mem[0]=19'h7FFFF, load_count=2.
- Partial discard: load_start addr=5; 2 bytes then load_stop -> mem[5] still 0, load_count=0; stop with 3rd byte same cycle -> word written, count=1.
- Simultaneous/ignored: fetch_req addr=2 with load_start same cycle -> fetch_valid next cycle with old data; fetch_req during LOAD -> fetch_valid stays 0.
- Reset mid-load: after 1 byte, rst -> CLEAR restarts, load_byte_ready=0, load_count=0, memory all zero afterwards.

Source files
------------

// File: rtl/instr_mem_loadable_pkg.sv
// rtl/instr_mem_loadable_pkg.sv - shared state type, default widths and load sizing
package instr_mem_loadable_pkg;

  localparam int DEFAULT_INSTR_WIDTH = 19;
  localparam int DEFAULT_ADDR_WIDTH  = 12;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } mem_state_t;

  function automatic int load_bytes(input int instr_width);
    return (instr_width + 7) / 8;
  endfunction

endpackage

// File: rtl/instr_word_assembler.sv
// rtl/instr_word_assembler.sv - packs MSB-first program bytes into instruction words
module instr_word_assembler
  import instr_mem_loadable_pkg::*;
#(
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int LOAD_BYTES  = load_bytes(INSTR_WIDTH)
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   word_done,
  output logic [INSTR_WIDTH-1:0] word
);

  localparam int PW = 8 * LOAD_BYTES;

  logic [2:0]    byte_idx;
  logic [PW-1:0] partial;
  logic [PW+7:0] cat;

  // The completing byte is combined combinationally so the word is written on the same edge.
  assign cat       = {partial, byte_data};
  assign word      = cat[INSTR_WIDTH-1:0];
  assign word_done = byte_valid && (byte_idx == 3'(LOAD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      byte_idx <= '0;
      partial  <= '0;
    end else if (word_done) begin
      byte_idx <= '0;
      partial  <= '0;
    end else if (byte_valid) begin
      byte_idx <= byte_idx + 3'd1;
      partial  <= cat[PW-1:0];
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - instruction store with hardware clear sweep and byte-serial loader
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_valid,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   mem_ready,
  input  logic                   load_start,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic                   load_byte_valid,
  input  logic [7:0]             load_byte,
  output logic                   load_byte_ready,
  input  logic                   load_stop,
  output logic [ADDR_WIDTH:0]    load_count
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int LOAD_BYTES = load_bytes(INSTR_WIDTH);
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  mem_state_t             state;
  logic [ADDR_WIDTH-1:0]  sweep_addr;
  logic [ADDR_WIDTH-1:0]  load_ptr;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic                   byte_accept;
  logic                   asm_clear;
  logic                   word_done;
  logic [INSTR_WIDTH-1:0] asm_word;
  logic                   we;
  logic [ADDR_WIDTH-1:0]  waddr;
  logic [INSTR_WIDTH-1:0] wdata;

  // A restart in LOAD drops any byte offered in the same cycle.
  assign byte_accept = (state == ST_LOAD) && load_byte_valid && !load_start;
  assign asm_clear   = rst || (load_start && state != ST_CLEAR) ||
                       (state == ST_LOAD && load_stop);

  instr_word_assembler #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .LOAD_BYTES  (LOAD_BYTES)
  ) u_assembler (
    .clk        (clk),
    .clear      (asm_clear),
    .byte_valid (byte_accept),
    .byte_data  (load_byte),
    .word_done  (word_done),
    .word       (asm_word)
  );

  assign we    = !rst && ((state == ST_CLEAR) || word_done);
  assign waddr = (state == ST_CLEAR) ? sweep_addr : load_ptr;
  assign wdata = (state == ST_CLEAR) ? '0 : asm_word;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_CLEAR;
      sweep_addr      <= '0;
      load_ptr        <= '0;
      fetch_valid     <= 1'b0;
      instruction     <= '0;
      mem_ready       <= 1'b0;
      load_byte_ready <= 1'b0;
      load_count      <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          fetch_valid <= 1'b0;
          sweep_addr  <= sweep_addr + 1'b1;
          if (sweep_addr == {ADDR_WIDTH{1'b1}}) begin
            state     <= ST_RUN;
            mem_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          fetch_valid <= fetch_req;
          if (fetch_req) instruction <= mem[fetch_addr];
          if (load_start) begin
            state           <= ST_LOAD;
            load_ptr        <= load_addr;
            load_count      <= '0;
            mem_ready       <= 1'b0;
            load_byte_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          fetch_valid <= 1'b0;
          if (load_start) begin
            load_ptr   <= load_addr;
            load_count <= '0;
          end else begin
            if (word_done) begin
              load_ptr <= load_ptr + 1'b1;
              if (load_count != COUNT_MAX) load_count <= load_count + 1'b1;
            end
            if (load_stop) begin
              state           <= ST_RUN;
              mem_ready       <= 1'b1;
              load_byte_ready <= 1'b0;
            end
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - directed bench for instr_mem_loadable at 4-bit address
module tb_instr_mem_loadable;

  localparam int IW = 19;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [IW-1:0] instruction;
  logic          mem_ready;
  logic          load_start;
  logic [AW-1:0] load_addr;
  logic          load_byte_valid;
  logic [7:0]    load_byte;
  logic          load_byte_ready;
  logic          load_stop;
  logic [AW:0]   load_count;

  int checks = 0;
  int errors = 0;

  instr_mem_loadable #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_valid     (fetch_valid),
    .instruction     (instruction),
    .mem_ready       (mem_ready),
    .load_start      (load_start),
    .load_addr       (load_addr),
    .load_byte_valid (load_byte_valid),
    .load_byte       (load_byte),
    .load_byte_ready (load_byte_ready),
    .load_stop       (load_stop),
    .load_count      (load_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte_valid = 1'b1;
    load_byte = b;
    step();
    load_byte_valid = 1'b0;
  endtask

  task automatic start_load(input logic [AW-1:0] a);
    load_start = 1'b1;
    load_addr = a;
    step();
    load_start = 1'b0;
  endtask

  task automatic stop_load();
    load_stop = 1'b1;
    step();
    load_stop = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [AW-1:0] a, input logic [IW-1:0] exp);
    fetch_req = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    check({tag, "_data"}, 32'(instruction), 32'(exp));
    step();
    check({tag, "_idle"}, 32'(fetch_valid), 32'd0);
    check({tag, "_hold"}, 32'(instruction), 32'(exp));
  endtask

  task automatic wait_clear(input string tag);
    int early = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (mem_ready !== 1'b0) early++;
    end
    check({tag, "_low15"}, 32'(early), 32'd0);
    step();
    check({tag, "_ready"}, 32'(mem_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0; load_addr = '0;
    load_byte_valid = 1'b0; load_byte = '0; load_stop = 1'b0;
    step();
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_fvalid", 32'(fetch_valid), 32'd0);
    check("rst_instr", 32'(instruction), 32'd0);
    check("rst_bready", 32'(load_byte_ready), 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    rst = 1'b0;
    wait_clear("clr0");

    // basic load
    start_load(4'd2);
    check("ld_bready", 32'(load_byte_ready), 32'd1);
    check("ld_mready", 32'(mem_ready), 32'd0);
    send_byte(8'h01); send_byte(8'hA2); send_byte(8'hF7);
    check("ld_count", 32'(load_count), 32'd1);
    stop_load();
    check("ld_back", 32'(mem_ready), 32'd1);
    check("ld_bready0", 32'(load_byte_ready), 32'd0);
    fetch("f2", 4'd2, 19'h1A2F7);
    fetch("f1", 4'd1, 19'h0);
    fetch("f3", 4'd3, 19'h0);

    // wrap-around and surplus high bits
    start_load(4'd15);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hF7); send_byte(8'hFF); send_byte(8'hFF);
    check("wr_count", 32'(load_count), 32'd2);
    stop_load();
    fetch("f15", 4'd15, 19'h00001);
    fetch("f0", 4'd0, 19'h7FFFF);

    // partial discard, then stop coinciding with the final byte
    start_load(4'd5);
    send_byte(8'h11); send_byte(8'h22);
    stop_load();
    check("pd_count", 32'(load_count), 32'd0);
    fetch("f5a", 4'd5, 19'h0);
    start_load(4'd5);
    send_byte(8'hAA); send_byte(8'hBB);
    load_byte_valid = 1'b1; load_byte = 8'hCC; load_stop = 1'b1;
    step();
    load_byte_valid = 1'b0; load_stop = 1'b0;
    check("ps_count", 32'(load_count), 32'd1);
    check("ps_ready", 32'(mem_ready), 32'd1);
    fetch("f5b", 4'd5, 19'h2BBCC);
    fetch("f6", 4'd6, 19'h0);

    // fetch alongside load_start, fetch ignored in LOAD, restart in LOAD
    fetch_req = 1'b1; fetch_addr = 4'd2; load_start = 1'b1; load_addr = 4'd8;
    step();
    load_start = 1'b0;
    check("sim_valid", 32'(fetch_valid), 32'd1);
    check("sim_data", 32'(instruction), 32'h1A2F7);
    check("sim_bready", 32'(load_byte_ready), 32'd1);
    step();
    check("ign_valid1", 32'(fetch_valid), 32'd0);
    step();
    fetch_req = 1'b0;
    check("ign_valid2", 32'(fetch_valid), 32'd0);
    send_byte(8'h12);
    start_load(4'd9);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    check("rs_count", 32'(load_count), 32'd1);
    stop_load();
    fetch("f9", 4'd9, 19'h5);
    fetch("f8", 4'd8, 19'h0);

    // reset mid-load clears everything
    start_load(4'd3);
    send_byte(8'h55);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rml_bready", 32'(load_byte_ready), 32'd0);
    check("rml_count", 32'(load_count), 32'd0);
    check("rml_ready", 32'(mem_ready), 32'd0);
    wait_clear("clr1");

    // back-to-back fetches of the whole array
    for (int i = 0; i < 16; i++) begin
      fetch_req = 1'b1;
      fetch_addr = 4'(i);
      step();
      check("b2b_valid", 32'(fetch_valid), 32'd1);
      check("b2b_data", 32'(instruction), 32'd0);
    end
    fetch_req = 1'b0;
    step();
    check("b2b_end", 32'(fetch_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
